// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_write_arbiter_pkg                                   |
// | Description : Shared widths and buffered-write entry type            |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package wb_write_arbiter_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_REG_W  = 5;

    typedef struct packed {
        logic [c_REG_W-1:0]  regIdx;
        logic [c_DATA_W-1:0] data;
        logic                live;
    } wb_entry_t;

endpackage : wb_write_arbiter_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_fifo                                                |
// | Description : Circular buffer of pending writes, kill-by-tag, query  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module wb_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  wb_entry_t                  i_pushEntry,
    input  logic                       i_pop,
    input  logic                       i_kill,
    input  logic [c_REG_W-1:0]         i_killReg,
    input  logic [c_REG_W-1:0]         i_queryReg,
    output logic                       o_queryHit,
    output wb_entry_t                  o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t             r_mem [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [c_PTR_W-1:0]    r_wrPtr;
    logic [c_PTR_W-1:0]    r_rdPtr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_doPush;
    logic                  w_doPop;
    logic [DEPTH-1:0]      w_match;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_doPush = i_push && !w_full;
    assign w_doPop  = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            // Kill is applied before the push so a same-cycle push stays live.
            if (i_kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i] && (r_mem[i].regIdx == i_killReg)) begin
                        r_mem[i].live <= 1'b0;
                    end
                end
            end
            if (w_doPop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + 1'b1;
            end
            if (w_doPush) begin
                r_mem[r_wrPtr]   <= i_pushEntry;
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_match
            assign w_match[g] = r_valid[g] && r_mem[g].live &&
                                (r_mem[g].regIdx == i_queryReg);
        end
    endgenerate

    assign o_queryHit = (i_queryReg != '0) && (|w_match);
    assign o_head     = r_mem[r_rdPtr];
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_write_arbiter                                       |
// | Description : Merges pipeline and long-latency writes onto the       |
// |               register-file write port, preserving WAW order         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int REG_W  = c_REG_W,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_we,
    input  logic [REG_W-1:0]          pipe_reg,
    input  logic [DATA_W-1:0]         pipe_data,
    input  logic                      lu_valid,
    input  logic [REG_W-1:0]          lu_reg,
    input  logic [DATA_W-1:0]         lu_data,
    output logic                      lu_ready,
    input  logic [REG_W-1:0]          query_reg,
    output logic                      query_busy,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      RegWrite,
    output logic [REG_W-1:0]          WriteReg,
    output logic [DATA_W-1:0]         WriteData
);

    logic       w_pipeWr;
    logic       w_push;
    logic       w_pop;
    logic       w_empty;
    logic       w_full;
    wb_entry_t  w_pushEntry;
    wb_entry_t  w_head;

    // Writes to $0 never reach the register file, so they leave the port idle.
    assign w_pipeWr = pipe_we && (pipe_reg != '0);
    assign lu_ready = !w_full;
    assign w_push   = lu_valid && lu_ready && (lu_reg != '0);
    assign w_pop    = !w_pipeWr && !w_empty;

    assign w_pushEntry = '{regIdx: lu_reg, data: lu_data, live: 1'b1};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_pop),
        .i_kill      (w_pipeWr),
        .i_killReg   (pipe_reg),
        .i_queryReg  (query_reg),
        .o_queryHit  (query_busy),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (w_pipeWr) begin
            RegWrite  <= 1'b1;
            WriteReg  <= pipe_reg;
            WriteData <= pipe_data;
        end else if (w_pop) begin
            // A killed head still consumes the slot but produces no write.
            RegWrite <= w_head.live;
            if (w_head.live) begin
                WriteReg  <= w_head.regIdx;
                WriteData <= w_head.data;
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule : wb_write_arbiter
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_wb_write_arbiter                                    |
// | Description : Scoreboard bench for wb_write_arbiter                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_wb_write_arbiter;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_reg;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  query_reg;
    logic        query_busy;
    logic [2:0]  fifo_count;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    int  nChecks = 0;
    int  nErrors = 0;
    wr_t r_expQ[$];

    wb_write_arbiter #(
        .DATA_W (32),
        .REG_W  (5),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_reg   (pipe_reg),
        .pipe_data  (pipe_data),
        .lu_valid   (lu_valid),
        .lu_reg     (lu_reg),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .query_reg  (query_reg),
        .query_busy (query_busy),
        .fifo_count (fifo_count),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        r_expQ.push_back(e);
    endtask

    // Monitor: every register-file write must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (RegWrite === 1'b1) begin
                nChecks++;
                if (r_expQ.size() == 0) begin
                    nErrors++;
                    $display("FAIL unexpected_write: got r%0d=%h expected no write", WriteReg, WriteData);
                end else begin
                    e = r_expQ.pop_front();
                    if (WriteReg !== e.r || WriteData !== e.d) begin
                        nErrors++;
                        $display("FAIL write_order: got r%0d=%h expected r%0d=%h",
                                 WriteReg, WriteData, e.r, e.d);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_reg = '0; lu_data = '0; query_reg = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset / idle state
        check("reset_regwrite", 32'(RegWrite), 32'd0);
        check("reset_lu_ready", 32'(lu_ready), 32'd1);
        check("reset_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 32; i++) begin
            query_reg = 5'(i);
            #1;
            check("reset_query_busy", 32'(query_busy), 32'd0);
        end

        // Single lu push drains next cycle
        lu_valid = 1'b1; lu_reg = 5'd5; lu_data = 32'hAAAA0001;
        expect_wr(5'd5, 32'hAAAA0001);
        step();
        lu_valid = 1'b0; query_reg = 5'd5;
        #1;
        check("single_count1", 32'(fifo_count), 32'd1);
        check("single_busy", 32'(query_busy), 32'd1);
        step();
        check("single_count0", 32'(fifo_count), 32'd0);

        // Contention: pipe has priority, lu fills FIFO
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1'b1; lu_reg = 5'(i + 1); lu_data = 32'h1000 + 32'(i);
            pipe_we = 1'b1; pipe_reg = 5'(8 + i); pipe_data = 32'h2000 + 32'(i);
            expect_wr(5'(8 + i), 32'h2000 + 32'(i));
            step();
            check("contend_count", 32'(fifo_count), 32'(i + 1));
        end
        lu_valid = 1'b0; pipe_we = 1'b0;
        #1;
        check("full_lu_ready", 32'(lu_ready), 32'd0);
        for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h1000 + 32'(i));
        repeat (4) step();
        check("drain_count", 32'(fifo_count), 32'd0);
        check("drain_lu_ready", 32'(lu_ready), 32'd1);

        // WAW kill
        lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h11;
        step();
        lu_valid = 1'b0; query_reg = 5'd7;
        #1;
        check("waw_busy_before", 32'(query_busy), 32'd1);
        pipe_we = 1'b1; pipe_reg = 5'd7; pipe_data = 32'h22;
        expect_wr(5'd7, 32'h22);
        step();
        pipe_we = 1'b0;
        #1;
        check("waw_busy_after", 32'(query_busy), 32'd0);
        check("waw_count_killed", 32'(fifo_count), 32'd1);
        step();
        check("waw_count_drained", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("waw_killed_slot_idle", 32'(RegWrite), 32'd0);
        #4;

        // Same-cycle push and pipe write to r9: push is younger, survives
        lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h99;
        pipe_we = 1'b1; pipe_reg = 5'd9; pipe_data = 32'h90;
        expect_wr(5'd9, 32'h90);
        expect_wr(5'd9, 32'h99);
        step();
        lu_valid = 1'b0; pipe_we = 1'b0; query_reg = 5'd9;
        #1;
        check("same_cycle_busy", 32'(query_busy), 32'd1);
        step();
        check("same_cycle_count", 32'(fifo_count), 32'd0);

        // $0 pipe write leaves port idle, FIFO pops
        lu_valid = 1'b1; lu_reg = 5'd3; lu_data = 32'h33;
        expect_wr(5'd3, 32'h33);
        step();
        lu_valid = 1'b0;
        pipe_we = 1'b1; pipe_reg = 5'd0; pipe_data = 32'hDEAD;
        step();
        pipe_we = 1'b0;
        #1;
        check("r0_pipe_pops", 32'(fifo_count), 32'd0);

        // lu write to $0 is accepted but not buffered
        lu_valid = 1'b1; lu_reg = 5'd0; lu_data = 32'hBEEF;
        #1;
        check("r0_lu_ready", 32'(lu_ready), 32'd1);
        step();
        lu_valid = 1'b0; query_reg = 5'd0;
        #1;
        check("r0_lu_count", 32'(fifo_count), 32'd0);
        check("r0_query", 32'(query_busy), 32'd0);

        // Reset with entries buffered
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1; lu_reg = 5'(12 + i); lu_data = 32'h3000 + 32'(i);
            pipe_we = 1'b1; pipe_reg = 5'(20 + i); pipe_data = 32'h4000 + 32'(i);
            expect_wr(5'(20 + i), 32'h4000 + 32'(i));
            step();
        end
        lu_valid = 1'b0; pipe_we = 1'b0;
        #1;
        check("prereset_count", 32'(fifo_count), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_count", 32'(fifo_count), 32'd0);
        check("midreset_regwrite", 32'(RegWrite), 32'd0);
        query_reg = 5'd12;
        #1;
        check("midreset_query", 32'(query_busy), 32'd0);
        repeat (6) step();
        check("scoreboard_drained", 32'(r_expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_wb_write_arbiter
`default_nettype wire
